program_loader: RTL and testbench

- Upstream boot stage for the RISC15 multicycle core.
- Accepts a framed program over a 16-bit valid/ready word stream and writes it into the 64-word instruction/data memory.
- Checks a 16-bit additive checksum over the loaded words.
- Holds the core in reset until a clean load completes, then releases it.
- Sits between the host/testbench word source and the memory write port plus the core reset input.

---
 rtl/program_loader_pkg.sv | 28 ++
 rtl/loader_csum.sv | 39 +++
 rtl/program_loader.sv | 162 ++++++++++++++++
 tb/tb_program_loader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the RISC15 boot loader and its instruction/data memory.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the loader state encoding, the memory geometry defaults shared with
// the 64-word memory, and the largest program length a single frame may carry.
package program_loader_pkg;

    localparam int PL_ADDR_W = 6;
    localparam int PL_DATA_W = 16;

    // A frame may fill the whole memory but no more.
    function automatic int max_len(input int addr_w);
        return 1 << addr_w;
    endfunction

    localparam int PL_MAX_LEN = max_len(PL_ADDR_W);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        RUN  = 3'd4,
        ERR  = 3'd5
    } state_t;

endpackage

// File: rtl/loader_csum.sv
// Additive checksum accumulator for the program loader.
// Latency: sum updates one cycle after add_en; match is combinational on the registered sum.
// Backpressure: none; adds whenever add_en is high.
//
// Ports:
//   clk, rst_n     - clock and synchronous active-low reset
//   clr            - zero the running sum (takes priority over add_en)
//   add_en/add_data- add add_data into the sum, modulo 2^DATA_W
//   cmp_data       - value compared against the current sum
//   sum, match     - running sum and (sum == cmp_data)
module loader_csum
    import program_loader_pkg::*;
#(
    parameter int DATA_W = PL_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              add_en,
    input  logic [DATA_W-1:0] add_data,
    input  logic [DATA_W-1:0] cmp_data,
    output logic [DATA_W-1:0] sum,
    output logic              match
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (add_en) begin
            // Natural wrap of the DATA_W-bit adder gives the modulo sum.
            sum <= sum + add_data;
        end
    end

    assign match = (sum == cmp_data);

endmodule

// File: rtl/program_loader.sv
// Boot loader: takes a length/data/checksum frame and writes it into core memory, then releases the core.
// Latency: memory write one cycle after a data word is accepted; done/err one cycle after the checksum word.
// Backpressure: ld_ready is high throughout LEN/DATA/CSUM; every valid word is taken, no skid buffer.
//
// Ports:
//   clk, proc_rst          - clock and synchronous active-low reset
//   ld_start               - pulse to begin a load (honoured in IDLE/RUN/ERR only)
//   ld_valid/ld_ready/ld_data - 16-bit word stream: length, N data words, checksum
//   mem_addr/mem_wdata/mem_we - memory write port, one pulse per data word
//   core_hold              - core reset, high until a load succeeds
//   done, err              - load outcome
//   words_loaded           - data words written by the current or last load
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W     = PL_ADDR_W,
    parameter int DATA_W     = PL_DATA_W,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              proc_rst,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              core_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [31:0] MAX_LEN_U = 32'(max_len(ADDR_W));

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   remaining;
    logic              accept;
    logic              len_bad;
    logic              csum_clr;
    logic              csum_add;
    logic              csum_match;
    logic [DATA_W-1:0] csum_sum;

    assign accept   = ld_valid & ld_ready;
    // Length must be 1..2^ADDR_W; compare in 32 bits so large words never alias.
    assign len_bad  = (ld_data == '0) || (32'(ld_data) > MAX_LEN_U);
    assign csum_clr = accept && (state == LEN);
    assign csum_add = accept && (state == DATA);

    loader_csum #(
        .DATA_W (DATA_W)
    ) u_csum (
        .clk      (clk),
        .rst_n    (proc_rst),
        .clr      (csum_clr),
        .add_en   (csum_add),
        .add_data (ld_data),
        .cmp_data (ld_data),
        .sum      (csum_sum),
        .match    (csum_match)
    );

    always_ff @(posedge clk) begin
        if (!proc_rst) begin
            state        <= IDLE;
            ld_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            core_hold    <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            ptr          <= '0;
            remaining    <= '0;
        end else begin
            // Write strobe is a single-cycle pulse; only a DATA acceptance raises it.
            mem_we <= 1'b0;

            case (state)
                IDLE: begin
                    if (ld_start) begin
                        state     <= LEN;
                        ld_ready  <= 1'b1;
                        core_hold <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                    end
                end

                LEN: begin
                    if (accept) begin
                        if (len_bad) begin
                            state    <= ERR;
                            ld_ready <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            state        <= DATA;
                            remaining    <= ld_data[ADDR_W:0];
                            ptr          <= ADDR_W'(START_ADDR);
                            words_loaded <= '0;
                        end
                    end
                end

                DATA: begin
                    if (accept) begin
                        mem_we       <= 1'b1;
                        mem_addr     <= ptr;
                        mem_wdata    <= ld_data;
                        // Pointer wraps at the top of memory by width.
                        ptr          <= ptr + 1'b1;
                        words_loaded <= words_loaded + 1'b1;
                        remaining    <= remaining - 1'b1;
                        if (remaining == (ADDR_W+1)'(1)) begin
                            state <= CSUM;
                        end
                    end
                end

                CSUM: begin
                    if (accept) begin
                        ld_ready <= 1'b0;
                        if (csum_match) begin
                            state     <= RUN;
                            core_hold <= 1'b0;
                            done      <= 1'b1;
                            err       <= 1'b0;
                        end else begin
                            state     <= ERR;
                            core_hold <= 1'b1;
                            done      <= 1'b0;
                            err       <= 1'b1;
                        end
                    end
                end

                RUN, ERR: begin
                    if (ld_start) begin
                        state     <= LEN;
                        ld_ready  <= 1'b1;
                        core_hold <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    ld_ready  <= 1'b0;
                    core_hold <= 1'b1;
                    done      <= 1'b0;
                    err       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frames, checksum, length limits, gaps, reset abort.
// Latency: n/a.
// Backpressure: n/a.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        proc_rst;
    logic        ld_start;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic [5:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        core_hold;
    logic        done;
    logic        err;
    logic [6:0]  words_loaded;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [5:0]  wq_addr[$];
    logic [15:0] wq_data[$];
    int          wq_cyc[$];

    always #5 clk = ~clk;

    program_loader dut (
        .clk          (clk),
        .proc_rst     (proc_rst),
        .ld_start     (ld_start),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .ld_ready     (ld_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .core_hold    (core_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always @(posedge clk) cyc++;

    // Write capture: outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wdata);
            wq_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_writes();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
    endtask

    task automatic pulse_start();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        int n;
        n = 0;
        ld_valid = 1'b1;
        ld_data  = w;
        @(negedge clk);
        while (ld_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_word_timeout word=%h ld_ready=%b required 1", w, ld_ready);
        end
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && err !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1 && err !== 1'b1) begin
            errors++;
            $display("FAIL wait_result_timeout done=%b err=%b required one of them 1", done, err);
        end
        tick();
    endtask

    task automatic test_reset();
        proc_rst = 1'b0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        tick();
        tick();
        checks++; if (core_hold !== 1'b1) begin errors++; $display("FAIL reset_core_hold got %b req 1", core_hold); end
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready got %b req 0", ld_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b req 0", mem_we); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b req 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b req 0", err); end
        checks++; if (words_loaded !== 7'd0) begin errors++; $display("FAIL reset_words_loaded got %0d req 0", words_loaded); end
        proc_rst = 1'b1;
        tick();
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL idle_ld_ready got %b req 0", ld_ready); end
    endtask

    task automatic test_normal_load();
        logic [15:0] dat[3];
        dat[0] = 16'h1111; dat[1] = 16'h2222; dat[2] = 16'h3333;
        clear_writes();
        pulse_start();
        send_word(16'd3);
        for (int i = 0; i < 3; i++) send_word(dat[i]);
        send_word(16'h6666);
        wait_result();
        checks++; if (wq_addr.size() != 3) begin errors++; $display("FAIL normal_write_count got %0d req 3", wq_addr.size()); end
        for (int i = 0; i < 3 && i < wq_addr.size(); i++) begin
            checks++; if (wq_addr[i] !== 6'(i)) begin errors++; $display("FAIL normal_addr[%0d] got %0d req %0d", i, wq_addr[i], i); end
            checks++; if (wq_data[i] !== dat[i]) begin errors++; $display("FAIL normal_data[%0d] got %h req %h", i, wq_data[i], dat[i]); end
        end
        if (wq_cyc.size() == 3) begin
            checks++; if (wq_cyc[2] - wq_cyc[0] != 2) begin errors++; $display("FAIL normal_back_to_back span got %0d req 2", wq_cyc[2] - wq_cyc[0]); end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL normal_done got %b req 1", done); end
        checks++; if (core_hold !== 1'b0) begin errors++; $display("FAIL normal_core_hold got %b req 0", core_hold); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL normal_err got %b req 0", err); end
        checks++; if (words_loaded !== 7'd3) begin errors++; $display("FAIL normal_words_loaded got %0d req 3", words_loaded); end
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL normal_ld_ready got %b req 0", ld_ready); end
    endtask

    task automatic test_bad_csum();
        clear_writes();
        pulse_start();
        // Restart from RUN must re-hold the core and drop done at once.
        checks++; if (core_hold !== 1'b1) begin errors++; $display("FAIL restart_core_hold got %b req 1", core_hold); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL restart_done got %b req 0", done); end
        send_word(16'd3);
        send_word(16'h1111);
        send_word(16'h2222);
        send_word(16'h3333);
        send_word(16'h6667);
        wait_result();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL badcsum_err got %b req 1", err); end
        checks++; if (core_hold !== 1'b1) begin errors++; $display("FAIL badcsum_core_hold got %b req 1", core_hold); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL badcsum_done got %b req 0", done); end
        checks++; if (wq_addr.size() != 3) begin errors++; $display("FAIL badcsum_write_count got %0d req 3", wq_addr.size()); end
        checks++; if (words_loaded !== 7'd3) begin errors++; $display("FAIL badcsum_words_loaded got %0d req 3", words_loaded); end
    endtask

    task automatic test_illegal_len();
        logic [15:0] lens[2];
        lens[0] = 16'd0;
        lens[1] = 16'd65;
        for (int k = 0; k < 2; k++) begin
            clear_writes();
            pulse_start();
            send_word(lens[k]);
            wait_result();
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_len%0d_err got %b req 1", lens[k], err); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL illegal_len%0d_done got %b req 0", lens[k], done); end
            checks++; if (wq_addr.size() != 0) begin errors++; $display("FAIL illegal_len%0d_writes got %0d req 0", lens[k], wq_addr.size()); end
            checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL illegal_len%0d_ld_ready got %b req 0", lens[k], ld_ready); end
        end
    endtask

    task automatic test_max_len();
        int bad;
        clear_writes();
        pulse_start();
        send_word(16'd64);
        for (int i = 0; i < 64; i++) send_word(16'h0001);
        send_word(16'h0040);
        wait_result();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL max_done got %b req 1", done); end
        checks++; if (wq_addr.size() != 64) begin errors++; $display("FAIL max_write_count got %0d req 64", wq_addr.size()); end
        if (wq_addr.size() == 64) begin
            checks++; if (wq_addr[63] !== 6'd63) begin errors++; $display("FAIL max_last_addr got %0d req 63", wq_addr[63]); end
            bad = 0;
            for (int i = 0; i < 64; i++) if (wq_addr[i] !== 6'(i) || wq_data[i] !== 16'h0001) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL max_sequence got %0d bad writes req 0", bad); end
        end
        checks++; if (words_loaded !== 7'd64) begin errors++; $display("FAIL max_words_loaded got %0d req 64", words_loaded); end
    endtask

    task automatic test_backpressure_gaps();
        logic [15:0] dat[5];
        int gap;
        dat[0] = 16'hA001; dat[1] = 16'h0B02; dat[2] = 16'h00C3; dat[3] = 16'hFFFF; dat[4] = 16'h1234;
        clear_writes();
        pulse_start();
        send_word(16'd5);
        // A start request mid-frame must be ignored.
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                tick();
                checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL gap_ld_ready word%0d got %b req 1", i, ld_ready); end
            end
            if (i < 5) send_word(dat[i]);
            else send_word(16'hBDF9);
        end
        wait_result();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL gaps_done got %b req 1", done); end
        checks++; if (wq_addr.size() != 5) begin errors++; $display("FAIL gaps_write_count got %0d req 5", wq_addr.size()); end
        for (int i = 0; i < 5 && i < wq_addr.size(); i++) begin
            checks++; if (wq_addr[i] !== 6'(i) || wq_data[i] !== dat[i]) begin
                errors++; $display("FAIL gaps_write[%0d] got %0d:%h req %0d:%h", i, wq_addr[i], wq_data[i], i, dat[i]);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [15:0] dat[5];
        dat[0] = 16'h0010; dat[1] = 16'h0020; dat[2] = 16'h0030; dat[3] = 16'h0040; dat[4] = 16'h0050;
        pulse_start();
        send_word(16'd5);
        send_word(dat[0]);
        send_word(dat[1]);
        proc_rst = 1'b0;
        tick();
        checks++; if (core_hold !== 1'b1) begin errors++; $display("FAIL midrst_core_hold got %b req 1", core_hold); end
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL midrst_ld_ready got %b req 0", ld_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL midrst_mem_we got %b req 0", mem_we); end
        checks++; if (words_loaded !== 7'd0) begin errors++; $display("FAIL midrst_words_loaded got %0d req 0", words_loaded); end
        proc_rst = 1'b1;
        tick();
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL midrst_idle_ready got %b req 0", ld_ready); end
        clear_writes();
        pulse_start();
        send_word(16'd5);
        for (int i = 0; i < 5; i++) send_word(dat[i]);
        send_word(16'h00F0);
        wait_result();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL reload_done got %b req 1", done); end
        checks++; if (core_hold !== 1'b0) begin errors++; $display("FAIL reload_core_hold got %b req 0", core_hold); end
        checks++; if (wq_addr.size() != 5) begin errors++; $display("FAIL reload_write_count got %0d req 5", wq_addr.size()); end
        if (wq_addr.size() == 5) begin
            checks++; if (wq_addr[0] !== 6'd0 || wq_data[4] !== 16'h0050) begin
                errors++; $display("FAIL reload_writes first_addr %0d last_data %h req 0 and 0050", wq_addr[0], wq_data[4]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal_load();
        test_bad_csum();
        test_illegal_len();
        test_max_len();
        test_backpressure_gaps();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
